// File: rtl/sequencer_param_if.sv
// ============================================================================
// Module      : sequencer_param_if
// Description : Control/status bundle between an instruction driver and
//               the sequencer_param controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sequencer_param_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
);
    logic             start;
    logic             nxt_line;
    logic             last;
    logic             step_mode;
    logic             step;
    logic             err;
    logic [ERR_W-1:0] err_code_in;
    logic             clr_err;
    logic [2:0]       q;
    logic [CNT_W-1:0] instr_cnt;
    logic [ERR_W-1:0] err_code;
    logic             busy;

    modport master (
        output start, nxt_line, last, step_mode, step, err, err_code_in, clr_err,
        input  q, instr_cnt, err_code, busy
    );

    modport slave (
        input  start, nxt_line, last, step_mode, step, err, err_code_in, clr_err,
        output q, instr_cnt, err_code, busy
    );
endinterface

`default_nettype wire

// File: rtl/sequencer_param.sv
// ============================================================================
// Module      : sequencer_param
// Description : Instruction sequencer (read/reg/calc/write) with single-step,
//               calc timeout and latched fault handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequencer_param #(
    parameter int MEM_WAIT     = 0,
    parameter int CALC_TIMEOUT = 16,
    parameter int CNT_W        = 8,
    parameter int ERR_W        = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sequencer_param_if.slave  bus
);

    localparam int              CALC_W     = $clog2(CALC_TIMEOUT);
    localparam logic [3:0]      WAIT_LAST  = 4'(MEM_WAIT);
    localparam logic [CALC_W-1:0] CALC_LAST = CALC_W'(CALC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        SRST    = 3'd0,
        SREAD   = 3'd1,
        SREG    = 3'd2,
        SCALC   = 3'd3,
        SWRITE  = 3'd4,
        SPAUSE  = 3'd5,
        SFINISH = 3'd6,
        SERR    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_q,  wait_d;
    logic [CALC_W-1:0]  calc_q,  calc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [ERR_W-1:0]   ecode_q, ecode_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SRST;
            wait_q  <= '0;
            calc_q  <= '0;
            cnt_q   <= '0;
            ecode_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            calc_q  <= calc_d;
            cnt_q   <= cnt_d;
            ecode_q <= ecode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        calc_d  = calc_q;
        cnt_d   = cnt_q;
        ecode_d = ecode_q;

        // An external fault pre-empts every other transition, timeout included.
        if (bus.err && (state_q != SERR)) begin
            state_d = SERR;
            ecode_d = bus.err_code_in;
        end else begin
            case (state_q)
                SRST, SFINISH: begin
                    if (bus.start) begin
                        state_d = SREAD;
                        wait_d  = '0;
                        cnt_d   = '0;
                    end
                end
                SREAD: begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = SREG;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
                SREG: begin
                    state_d = SCALC;
                    calc_d  = '0;
                end
                SCALC: begin
                    // calc_q holds the number of SCALC cycles already elapsed.
                    if (bus.nxt_line) begin
                        state_d = SWRITE;
                    end else if (calc_q == CALC_LAST) begin
                        state_d = SERR;
                        ecode_d = '1;
                    end else begin
                        calc_d = calc_q + CALC_W'(1);
                    end
                end
                SWRITE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.last) begin
                        state_d = SFINISH;
                    end else if (bus.step_mode) begin
                        state_d = SPAUSE;
                    end else begin
                        state_d = SREAD;
                        wait_d  = '0;
                    end
                end
                SPAUSE: begin
                    if (bus.step) begin
                        state_d = SREAD;
                        wait_d  = '0;
                    end
                end
                SERR: begin
                    if (bus.clr_err) begin
                        state_d = SRST;
                        ecode_d = '0;
                    end
                end
                default: begin
                    state_d = SRST;
                end
            endcase
        end
    end

    assign bus.q         = state_q;
    assign bus.instr_cnt = cnt_q;
    assign bus.err_code  = ecode_q;
    assign bus.busy      = (state_q == SREAD) || (state_q == SREG) ||
                           (state_q == SCALC) || (state_q == SWRITE);

endmodule

`default_nettype wire

// File: tb/tb_sequencer_param.sv
// Bench for sequencer_param: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model through a scoreboard queue.
`default_nettype none

module tb_sequencer_param;
    localparam int MW = 2;
    localparam int CT = 4;
    localparam int CW = 2;
    localparam int EW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vec = 0;
    int   fails = 0;

    sequencer_param_if #(.CNT_W(CW), .ERR_W(EW)) bus ();

    sequencer_param #(.MEM_WAIT(MW), .CALC_TIMEOUT(CT), .CNT_W(CW), .ERR_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int cnt;
        int ec;
        int busy;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: state number, cycles spent in the current state, counters.
    int m_st = 0, m_cyc = 0, m_cnt = 0, m_ec = 0;

    function automatic exp_t snap();
        exp_t e;
        e.q    = m_st;
        e.cnt  = m_cnt;
        e.ec   = m_ec;
        e.busy = (m_st >= 1 && m_st <= 4) ? 1 : 0;
        return e;
    endfunction

    task automatic enter_read();
        m_st  = 1;
        m_cyc = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_cyc = 0; m_cnt = 0; m_ec = 0;
            exp_q.delete();
        end else if (bus.err && m_st != 7) begin
            m_st = 7;
            m_ec = int'(bus.err_code_in);
        end else begin
            case (m_st)
                0, 6: if (bus.start) begin enter_read(); m_cnt = 0; end
                1: begin
                    m_cyc++;
                    if (m_cyc == 1 + MW) m_st = 2;
                end
                2: begin m_st = 3; m_cyc = 0; end
                3: begin
                    m_cyc++;
                    if (bus.nxt_line) m_st = 4;
                    else if (m_cyc == CT) begin m_st = 7; m_ec = (1 << EW) - 1; end
                end
                4: begin
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    if (bus.last) m_st = 6;
                    else if (bus.step_mode) m_st = 5;
                    else enter_read();
                end
                5: if (bus.step) enter_read();
                7: if (bus.clr_err) begin m_st = 0; m_ec = 0; end
                default: m_st = 0;
            endcase
        end
        exp_q.push_back(snap());
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vec++;
            if (int'(bus.q) != e.q || int'(bus.instr_cnt) != e.cnt ||
                int'(bus.err_code) != e.ec || int'(bus.busy) != e.busy) begin
                fails++;
                $display("FAIL scoreboard t=%0t act q=%0d cnt=%0d ec=%0d busy=%0d exp q=%0d cnt=%0d ec=%0d busy=%0d",
                         $time, bus.q, bus.instr_cnt, bus.err_code, bus.busy,
                         e.q, e.cnt, e.ec, e.busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_q(input string name, input int target, input int budget);
        int n = 0;
        while (int'(bus.q) != target && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(bus.q), target);
    endtask

    // Drives one instruction from SREAD through SWRITE and one edge beyond.
    task automatic run_instr(input bit lst);
        wait_q("reach_calc", 3, 20);
        bus.nxt_line = 1'b1;
        bus.last     = lst;
        tick();
        bus.nxt_line = 1'b0;
        chk("in_write", int'(bus.q), 4);
        tick();
        bus.last = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.nxt_line = 0; bus.last = 0; bus.step_mode = 0;
        bus.step = 0; bus.err = 0; bus.err_code_in = '0; bus.clr_err = 0;
        #1 rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_q", int'(bus.q), 0);
        chk("rst_cnt", int'(bus.instr_cnt), 0);
        chk("rst_ec", int'(bus.err_code), 0);
        chk("rst_busy", int'(bus.busy), 0);

        // MEM_WAIT=2 read sequence, nxt_line on second calc cycle
        bus.start = 1; tick(); bus.start = 0;
        chk("read1", int'(bus.q), 1);
        tick(); chk("read2", int'(bus.q), 1);
        tick(); chk("read3", int'(bus.q), 1);
        tick(); chk("sreg", int'(bus.q), 2);
        tick(); chk("calc1", int'(bus.q), 3);
        tick(); chk("calc2", int'(bus.q), 3);
        bus.nxt_line = 1; tick(); bus.nxt_line = 0;
        chk("write", int'(bus.q), 4);
        chk("write_busy", int'(bus.busy), 1);
        tick(); chk("back_to_read", int'(bus.q), 1);
        chk("cnt_after_one", int'(bus.instr_cnt), 1);

        // Calc timeout
        wait_q("to_calc", 3, 20);
        tick(); tick(); tick();
        chk("calc4_still", int'(bus.q), 3);
        tick();
        chk("timeout_q", int'(bus.q), 7);
        chk("timeout_ec", int'(bus.err_code), 15);
        bus.clr_err = 1; tick(); bus.clr_err = 0;
        chk("clr_q", int'(bus.q), 0);
        chk("clr_ec", int'(bus.err_code), 0);

        // Single-step
        bus.start = 1; tick(); bus.start = 0;
        bus.step_mode = 1;
        run_instr(1'b0);
        chk("pause_q", int'(bus.q), 5);
        chk("pause_busy", int'(bus.busy), 0);
        repeat (10) tick();
        chk("pause_hold", int'(bus.q), 5);
        bus.step = 1; tick(); bus.step = 0;
        chk("step_q", int'(bus.q), 1);
        chk("step_cnt", int'(bus.instr_cnt), 1);
        bus.step_mode = 0;

        // Finish and restart
        run_instr(1'b1);
        chk("finish1", int'(bus.q), 6);
        bus.start = 1; tick(); bus.start = 0;
        chk("restart_cnt", int'(bus.instr_cnt), 0);
        run_instr(1'b0);
        run_instr(1'b0);
        run_instr(1'b1);
        chk("finish_q", int'(bus.q), 6);
        chk("finish_cnt", int'(bus.instr_cnt), 3);
        bus.start = 1; tick(); bus.start = 0;
        chk("restart_q", int'(bus.q), 1);
        chk("restart_cnt0", int'(bus.instr_cnt), 0);

        // Fault latching
        wait_q("err_calc", 3, 20);
        bus.err = 1; bus.err_code_in = 4'h5; tick(); bus.err = 0;
        chk("err_q", int'(bus.q), 7);
        chk("err_ec", int'(bus.err_code), 5);
        bus.err = 1; bus.err_code_in = 4'h9; tick(); bus.err = 0;
        chk("err_hold", int'(bus.err_code), 5);
        bus.err = 1; bus.clr_err = 1; tick(); bus.err = 0; bus.clr_err = 0;
        chk("clr_wins_q", int'(bus.q), 0);
        chk("clr_wins_ec", int'(bus.err_code), 0);

        // err pulse in SRST
        bus.err = 1; bus.err_code_in = 4'h3; tick(); bus.err = 0;
        chk("srst_err", int'(bus.q), 7);
        bus.clr_err = 1; tick(); bus.clr_err = 0;

        // Counter wrap and async reset in SREAD
        bus.start = 1; tick(); bus.start = 0;
        repeat (5) run_instr(1'b0);
        chk("wrap_cnt", int'(bus.instr_cnt), 1);
        chk("wrap_q", int'(bus.q), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_q", int'(bus.q), 0);
        chk("async_rst_cnt", int'(bus.instr_cnt), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", int'(bus.q), 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                bus.start       = ($urandom_range(0, 9) < 3);
                bus.nxt_line    = ($urandom_range(0, 9) < 3);
                bus.last        = ($urandom_range(0, 9) < 2);
                bus.step_mode   = ($urandom_range(0, 9) < 3);
                bus.step        = ($urandom_range(0, 9) < 3);
                bus.err         = ($urandom_range(0, 39) == 0);
                bus.err_code_in = EW'($urandom);
                bus.clr_err     = ($urandom_range(0, 9) < 3);
                tick();
            end
        end
        bus.err = 0; bus.start = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sequencer_param.md
SEQUENCER_PARAM -- requirements
Module: sequencer_param

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning extra wait cycles spent in SREAD (0..15).
REQ-002 SHALL have parameter CALC_TIMEOUT, default 16, meaning maximum cycles allowed in SCALC (>=2).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the retired-instruction counter.
REQ-004 SHALL have parameter ERR_W, default 4, meaning width of the error code.
REQ-005 SHALL have port clk  input  1  system clock; all state changes occur on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  begin or restart execution from SRST or SFINISH.
REQ-008 SHALL have port nxt_line  input  1  calculation complete; leave SCALC.
REQ-009 SHALL have port last  input  1  current instruction is the final one; sampled in SWRITE.
REQ-010 SHALL have port step_mode  input  1  single-step enable.
REQ-011 SHALL have port step  input  1  advance one instruction from SPAUSE.
REQ-012 SHALL have port err  input  1  external fault.
REQ-013 SHALL have port err_code_in  input  ERR_W  fault code qualifying err.
REQ-014 SHALL have port clr_err  input  1  acknowledge the fault and leave SERR.
REQ-015 SHALL have port q  output  3  state: SRST=0, SREAD=1, SREG=2, SCALC=3, SWRITE=4, SPAUSE=5, SFINISH=6, SERR=7.
REQ-016 SHALL have port instr_cnt  output  CNT_W  count of instructions retired since the last start.
REQ-017 SHALL have port err_code  output  ERR_W  latched fault code.
REQ-018 SHALL have port busy  output  1  high in SREAD, SREG, SCALC and SWRITE.

Function
REQ-019 SRST: start -> SREAD, clearing instr_cnt to 0 in the same edge; otherwise hold.
REQ-020 SREAD: a wait counter SHALL hold q=SREAD for exactly 1+MEM_WAIT cycles, then go to SREG.
REQ-021 SREG -> SCALC unconditionally after 1 cycle; the calc counter clears on SCALC entry.
REQ-022 SCALC: nxt_line -> SWRITE; otherwise the calc counter increments each cycle.
REQ-023 Timeout: in the CALC_TIMEOUT-th SCALC cycle with nxt_line low -> SERR, err_code = all-ones; nxt_line in that cycle wins, giving SWRITE.
REQ-024 SWRITE: instr_cnt increments by 1, wrapping modulo 2^CNT_W; next state is SFINISH if last, else SPAUSE if step_mode, else SREAD.
REQ-025 SPAUSE: step -> SREAD; otherwise hold; busy low.
REQ-026 SFINISH: start -> SREAD with instr_cnt cleared to 0; otherwise hold.
REQ-027 err in any state except SERR SHALL force SERR on the next edge and latch err_code_in, overriding every other transition, including timeout.
REQ-028 SERR: err is ignored and err_code holds the first fault; clr_err -> SRST and clears err_code to 0; clr_err in the same cycle as err SHALL win.
REQ-029 err_code SHALL change only on entry to SERR or on clr_err.
REQ-030 A single err pulse in SRST SHALL also enter SERR.

Reset
REQ-031 rst high SHALL immediately force q=SRST, instr_cnt=0, err_code=0, busy=0, and clear the wait and calc counters, regardless of state or other inputs.
REQ-032 Reset asserted mid-SCALC or in SERR SHALL discard all progress; after release, operation resumes only on start.

Verification
REQ-033 MEM_WAIT=2: rst then start for 1 cycle -> q sequence 1,1,1,2,3; nxt_line on the 2nd SCALC cycle -> 4, then 1 (last=0).
REQ-034 CALC_TIMEOUT=4, nxt_line held low -> q=7 after 4 SCALC cycles with err_code=4'hF; clr_err -> q=0 and err_code=0.
REQ-035 step_mode=1: after SWRITE -> q=5 and busy=0; q holds with step low for 10 cycles; step -> q=1; instr_cnt=1.
REQ-036 Run 3 instructions with last=1 on the 3rd SWRITE -> q=6 and instr_cnt=3; start -> q=1 and instr_cnt=0.
REQ-037 err with err_code_in=4'h5 in SCALC, then err with 4'h9 in SERR -> err_code stays 5; err and clr_err together -> q=0.
REQ-038 CNT_W=2, 5 instructions retired -> instr_cnt=1 (wrap); rst asserted mid-SREAD -> q=0 asynchronously, before the next edge.
